// File: rtl/directory_controller.sv
// Home directory for two L1s: serialises readMiss/writeMiss/invalidate and tracks U/S/E state plus sharers per block.
// Ack 1 cycle after grant, reply 1 cycle later (or after the owner's write-back); requests wait (held by the cache) while busy.
module directory_controller #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int WB_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        msgC0In,
    input  logic [ADDR_W-1:0] addrC0In,
    output logic              ackC0,
    input  logic              wbC0In,
    input  logic [ADDR_W-1:0] wbAddrC0In,
    input  logic [DATA_W-1:0] wbDataC0In,
    output logic [2:0]        msgToC0,
    output logic [ADDR_W-1:0] addrToC0,
    output logic              dataReplyC0,
    output logic [DATA_W-1:0] replyDataC0,
    input  logic [2:0]        msgC1In,
    input  logic [ADDR_W-1:0] addrC1In,
    output logic              ackC1,
    input  logic              wbC1In,
    input  logic [ADDR_W-1:0] wbAddrC1In,
    input  logic [DATA_W-1:0] wbDataC1In,
    output logic [2:0]        msgToC1,
    output logic [ADDR_W-1:0] addrToC1,
    output logic              dataReplyC1,
    output logic [DATA_W-1:0] replyDataC1,
    output logic              busy,
    output logic              timeoutErr
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(WB_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, SEND, WAIT_WB, REPLY, UPDATE} state_t;
    typedef enum logic [1:0] {DIR_U, DIR_S, DIR_E} dir_t;
    typedef enum logic [1:0] {REQ_RD, REQ_WR, REQ_INV} req_t;

    localparam logic [2:0] MSG_FETCH = 3'b100;
    localparam logic [2:0] MSG_INV   = 3'b010;
    localparam logic [2:0] MSG_FINV  = 3'b001;

    state_t            state, stateNext;
    dir_t              dirState   [DEPTH];
    logic [1:0]        dirSharers [DEPTH];
    logic [DATA_W-1:0] mem        [DEPTH];

    logic              reqId;       // 0 = C0, 1 = C1
    logic [ADDR_W-1:0] addrQ;
    req_t              reqType;
    logic [CNT_W-1:0]  cnt;
    logic              lastGrant;

    logic              grantId;
    logic [2:0]        sendMsg;
    logic              timeoutHit;
    logic              wbMatch;
    logic [DATA_W-1:0] wbMatchData;
    logic              otherIn, ownedByOther;

    function automatic req_t decodeType(input logic [2:0] m);
        if (m[1])      return REQ_WR;
        else if (m[2]) return REQ_RD;
        else           return REQ_INV;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        grantId      = 1'b0;
        sendMsg      = 3'b000;
        timeoutHit   = 1'b0;
        otherIn      = dirSharers[addrQ][~reqId];
        ownedByOther = (dirState[addrQ] == DIR_E) && otherIn;
        wbMatch      = reqId ? (wbC0In && wbAddrC0In == addrQ) : (wbC1In && wbAddrC1In == addrQ);
        wbMatchData  = reqId ? wbDataC0In : wbDataC1In;
        case (state)
            IDLE: begin
                grantId = (|msgC0In && |msgC1In) ? ~lastGrant : ~(|msgC0In);
                // Write-backs win over any miss presented in the same cycle.
                if (!(wbC0In || wbC1In) && (|msgC0In || |msgC1In))
                    stateNext = LOOKUP;
            end
            LOOKUP: begin
                case (reqType)
                    REQ_RD: begin
                        if (ownedByOther) begin
                            sendMsg   = MSG_FETCH;
                            stateNext = WAIT_WB;
                        end else begin
                            stateNext = REPLY;
                        end
                    end
                    REQ_WR: begin
                        if (ownedByOther) begin
                            sendMsg   = MSG_FINV;
                            stateNext = WAIT_WB;
                        end else if (dirState[addrQ] == DIR_S && otherIn) begin
                            sendMsg   = MSG_INV;
                            stateNext = SEND;
                        end else begin
                            stateNext = REPLY;
                        end
                    end
                    default: begin
                        if (otherIn) sendMsg = MSG_INV;
                        stateNext = UPDATE;
                    end
                endcase
            end
            SEND:    stateNext = REPLY;
            WAIT_WB: begin
                if (wbMatch) begin
                    stateNext = REPLY;
                end else if (cnt == CNT_W'(WB_TIMEOUT - 1)) begin
                    timeoutHit = 1'b1;
                    stateNext  = REPLY;
                end
            end
            REPLY:   stateNext = UPDATE;
            UPDATE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dirState[i]   <= DIR_U;
                dirSharers[i] <= 2'b00;
            end
            reqId      <= 1'b0;
            addrQ      <= '0;
            reqType    <= REQ_RD;
            cnt        <= '0;
            lastGrant  <= 1'b1;
            timeoutErr <= 1'b0;
            msgToC0    <= 3'b000;
            msgToC1    <= 3'b000;
        end else begin
            msgToC0 <= reqId ? sendMsg : 3'b000;
            msgToC1 <= reqId ? 3'b000 : sendMsg;
            if (timeoutHit) timeoutErr <= 1'b1;
            if (state == LOOKUP)       cnt <= '0;
            else if (state == WAIT_WB) cnt <= cnt + CNT_W'(1);
            if (state == IDLE) begin
                if (wbC0In) begin
                    dirState[wbAddrC0In]   <= DIR_U;
                    dirSharers[wbAddrC0In] <= 2'b00;
                end
                if (wbC1In) begin
                    dirState[wbAddrC1In]   <= DIR_U;
                    dirSharers[wbAddrC1In] <= 2'b00;
                end
                if (stateNext == LOOKUP) begin
                    reqId   <= grantId;
                    addrQ   <= grantId ? addrC1In : addrC0In;
                    reqType <= decodeType(grantId ? msgC1In : msgC0In);
                end
            end
            if (state == UPDATE) begin
                lastGrant <= reqId;
                if (reqType == REQ_RD) begin
                    // A previous exclusive owner keeps its bit and becomes a sharer.
                    dirState[addrQ]          <= DIR_S;
                    dirSharers[addrQ][reqId] <= 1'b1;
                end else begin
                    dirState[addrQ]   <= DIR_E;
                    dirSharers[addrQ] <= reqId ? 2'b10 : 2'b01;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == IDLE) begin
                if (wbC0In) mem[wbAddrC0In] <= wbDataC0In;
                if (wbC1In) mem[wbAddrC1In] <= wbDataC1In;
            end else if (state == WAIT_WB && wbMatch) begin
                mem[addrQ] <= wbMatchData;
            end
        end
    end

    assign busy        = (state != IDLE);
    assign ackC0       = (state == LOOKUP) && !reqId;
    assign ackC1       = (state == LOOKUP) && reqId;
    assign dataReplyC0 = (state == REPLY) && !reqId;
    assign dataReplyC1 = (state == REPLY) && reqId;
    assign replyDataC0 = dataReplyC0 ? mem[addrQ] : '0;
    assign replyDataC1 = dataReplyC1 ? mem[addrQ] : '0;
    assign addrToC0    = (dataReplyC0 || msgToC0 != 3'b000) ? addrQ : '0;
    assign addrToC1    = (dataReplyC1 || msgToC1 != 3'b000) ? addrQ : '0;
endmodule

// File: tb/tb_directory_controller.sv
// Scoreboard bench: stimulus queues expected acks/messages/replies with their cycle; a negedge monitor pops and compares.
module tb_directory_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] msgC0In, msgC1In;
    logic [7:0] addrC0In, addrC1In;
    logic       wbC0In, wbC1In;
    logic [7:0] wbAddrC0In, wbAddrC1In, wbDataC0In, wbDataC1In;
    logic       ackC0, ackC1, dataReplyC0, dataReplyC1, busy, timeoutErr;
    logic [2:0] msgToC0, msgToC1;
    logic [7:0] addrToC0, addrToC1, replyDataC0, replyDataC1;

    directory_controller #(.ADDR_W(8), .DATA_W(8), .WB_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .msgC0In(msgC0In), .addrC0In(addrC0In), .ackC0(ackC0),
        .wbC0In(wbC0In), .wbAddrC0In(wbAddrC0In), .wbDataC0In(wbDataC0In),
        .msgToC0(msgToC0), .addrToC0(addrToC0), .dataReplyC0(dataReplyC0), .replyDataC0(replyDataC0),
        .msgC1In(msgC1In), .addrC1In(addrC1In), .ackC1(ackC1),
        .wbC1In(wbC1In), .wbAddrC1In(wbAddrC1In), .wbDataC1In(wbDataC1In),
        .msgToC1(msgToC1), .addrToC1(addrToC1), .dataReplyC1(dataReplyC1), .replyDataC1(replyDataC1),
        .busy(busy), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = ack, 1 = message to cache, 2 = data reply
    typedef struct {
        int         kind;
        int         port;
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;
    ev_t expq[$];

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic observe(input int kind, input int port, input logic [7:0] addr, input logic [7:0] data);
        ev_t e;
        nChecks++;
        if (expq.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d port=%0d cyc=%0d addr=%0h data=%0h expected none",
                     kind, port, cyc, addr, data);
        end else begin
            e = expq.pop_front();
            if (e.kind == kind && e.port == port && e.cyc == cyc && e.addr === addr && e.data === data)
                nPass++;
            else
                $display("FAIL event: got kind=%0d port=%0d cyc=%0d addr=%0h data=%0h expected kind=%0d port=%0d cyc=%0d addr=%0h data=%0h",
                         kind, port, cyc, addr, data, e.kind, e.port, e.cyc, e.addr, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (ackC0) observe(0, 0, 8'h00, 8'h00);
            if (ackC1) observe(0, 1, 8'h00, 8'h00);
            if (msgToC0 != 3'b000) observe(1, 0, addrToC0, {5'b0, msgToC0});
            if (msgToC1 != 3'b000) observe(1, 1, addrToC1, {5'b0, msgToC1});
            if (dataReplyC0) observe(2, 0, addrToC0, replyDataC0);
            if (dataReplyC1) observe(2, 1, addrToC1, replyDataC1);
        end
    end

    task automatic ex(input int kind, input int port, input int off, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind; e.port = port; e.cyc = cyc + off; e.addr = a; e.data = d;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setMsg(input int p, input logic [2:0] m, input logic [7:0] a);
        if (p == 0) begin msgC0In = m; addrC0In = a; end
        else        begin msgC1In = m; addrC1In = a; end
    endtask

    task automatic issue(input int p, input logic [2:0] m, input logic [7:0] a);
        setMsg(p, m, a);
        idle(1);
        setMsg(p, 3'b000, 8'h00);
    endtask

    task automatic wbDrive(input int p, input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin wbC0In = 1'b1; wbAddrC0In = a; wbDataC0In = d; end
        else        begin wbC1In = 1'b1; wbAddrC1In = a; wbDataC1In = d; end
        idle(1);
        wbC0In = 1'b0; wbC1In = 1'b0;
    endtask

    task automatic checkQuiet(input string name);
        check(name, {ackC0, ackC1, msgToC0, msgToC1, dataReplyC0, dataReplyC1, busy, timeoutErr,
                     addrToC0, addrToC1, replyDataC0, replyDataC1}, 64'h0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle(2);
        checkQuiet("reset_outputs");
        reset = 1'b0;
    endtask

    // Ack one cycle after issue, direct reply one cycle later; returns with the FSM back in IDLE.
    task automatic simpleReq(input int p, input logic [2:0] m, input logic [7:0] a, input logic [7:0] d);
        ex(0, p, 1, 8'h00, 8'h00);
        ex(2, p, 2, a, d);
        issue(p, m, a);
        check("busy_after_grant", busy, 1);
        idle(3);
    endtask

    initial begin
        reset = 1'b1;
        msgC0In = 0; msgC1In = 0; addrC0In = 0; addrC1In = 0;
        wbC0In = 0; wbC1In = 0; wbAddrC0In = 0; wbAddrC1In = 0; wbDataC0In = 0; wbDataC1In = 0;
        doReset();

        // Basic U readMiss after preloading memory with an unsolicited write-back.
        wbDrive(0, 8'h10, 8'hA5);
        simpleReq(0, 3'b100, 8'h10, 8'hA5);

        // Simultaneous readMisses after reset: C0 first (lastGrant = C1), C1 holds its request.
        doReset();
        ex(0, 0, 1, 8'h00, 8'h00);
        ex(2, 0, 2, 8'h10, 8'hA5);
        ex(0, 1, 5, 8'h00, 8'h00);
        ex(2, 1, 6, 8'h10, 8'hA5);
        setMsg(0, 3'b100, 8'h10);
        setMsg(1, 3'b100, 8'h10);
        idle(1);
        setMsg(0, 3'b000, 8'h00);
        idle(4);
        setMsg(1, 3'b000, 8'h00);
        idle(3);

        // C1 writeMiss on S {C0,C1}: invalidate C0, then reply.
        ex(0, 1, 1, 8'h00, 8'h00);
        ex(1, 0, 2, 8'h10, 8'h02);
        ex(2, 1, 3, 8'h10, 8'hA5);
        issue(1, 3'b010, 8'h10);
        idle(4);

        // C0 readMiss on E(C1): fetch, ignore stray write-backs, reply with the owner's data.
        ex(0, 0, 1, 8'h00, 8'h00);
        ex(1, 1, 2, 8'h10, 8'h04);
        ex(2, 0, 6, 8'h10, 8'h3C);
        issue(0, 3'b100, 8'h10);
        idle(2);
        wbDrive(1, 8'h11, 8'h99);
        wbDrive(0, 8'h10, 8'hEE);
        wbDrive(1, 8'h10, 8'h3C);
        idle(2);

        // Back to E(C1), then C0 writeMiss with no write-back: timeout after 15 cycles.
        ex(0, 1, 1, 8'h00, 8'h00);
        ex(1, 0, 2, 8'h10, 8'h02);
        ex(2, 1, 3, 8'h10, 8'h3C);
        issue(1, 3'b010, 8'h10);
        idle(4);
        ex(0, 0, 1, 8'h00, 8'h00);
        ex(1, 1, 2, 8'h10, 8'h01);
        ex(2, 0, 17, 8'h10, 8'h3C);
        issue(0, 3'b010, 8'h10);
        idle(15);
        check("timeout_not_yet", timeoutErr, 0);
        idle(1);
        check("timeout_set", timeoutErr, 1);
        idle(2);

        // Unsolicited write-back drops the E entry to U: next read replies directly.
        wbDrive(0, 8'h10, 8'h5A);
        simpleReq(1, 3'b100, 8'h10, 8'h5A);
        wbDrive(0, 8'h20, 8'h77);
        simpleReq(1, 3'b010, 8'h10, 8'h5A);
        simpleReq(0, 3'b100, 8'h20, 8'h77);

        // Multi-bit message resolves to writeMiss: invalidate C0 before replying.
        ex(0, 1, 1, 8'h00, 8'h00);
        ex(1, 0, 2, 8'h20, 8'h02);
        ex(2, 1, 3, 8'h20, 8'h77);
        issue(1, 3'b111, 8'h20);
        idle(4);

        // Reset while waiting for a fetch write-back aborts without a reply.
        ex(0, 0, 1, 8'h00, 8'h00);
        ex(1, 1, 2, 8'h10, 8'h04);
        issue(0, 3'b100, 8'h10);
        idle(2);
        check("timeout_sticky", timeoutErr, 1);
        check("busy_in_wait_wb", busy, 1);
        reset = 1'b1;
        idle(1);
        checkQuiet("reset_mid_op");
        idle(1);
        reset = 1'b0;
        simpleReq(1, 3'b100, 8'h10, 8'h5A);
        simpleReq(0, 3'b100, 8'h20, 8'h77);
        idle(2);

        check("pending_events", expq.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
